// File: rtl/tiny_cpu_prog_loader.sv
// Program-memory loader for the 4-bit accumulator CPU: takes a nibble-serial
// LEN/data/CSUM frame, verifies it and exposes a gated 16x8 instruction memory.
module tiny_cpu_prog_loader #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nib_in,
  input  logic       nib_stb,
  input  logic [3:0] cpu_addr,
  output logic [7:0] cpu_instr,
  output logic [3:0] last_addr,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LEN_H = 4'd1,
    ST_LEN_L = 4'd2,
    ST_DAT_H = 4'd3,
    ST_DAT_L = 4'd4,
    ST_CS_H  = 4'd5,
    ST_CS_L  = 4'd6,
    ST_DONE  = 4'd7,
    ST_ERR   = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  hi_q, hi_d;
  logic [4:0]  len_q, len_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  acc_q, acc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [3:0]  last_addr_q, last_addr_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic [7:0]  byte_s;
  logic [4:0]  cnt_inc_s;

  // Low nibble completes the byte in the same cycle it is strobed.
  assign byte_s    = {hi_q, nib_in};
  assign cnt_inc_s = cnt_q + 5'd1;

  // Next-state and datapath update for the frame parser.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    last_addr_d = last_addr_q;
    mem_d       = mem_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        // start takes priority; a coincident nibble is simply not consumed
        if (start) begin
          state_d = ST_LEN_H;
          cnt_d   = 5'd0;
          acc_d   = 8'h00;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_H, ST_DAT_H, ST_CS_H: begin
        if (nib_stb) begin
          hi_d = nib_in;
          if (state_q == ST_LEN_H) begin
            state_d = ST_LEN_L;
          end else if (state_q == ST_DAT_H) begin
            state_d = ST_DAT_L;
          end else begin
            state_d = ST_CS_L;
          end
        end else begin
          hi_d = hi_q;
        end
      end
      ST_LEN_L: begin
        if (nib_stb) begin
          if ((byte_s == 8'h00) || (byte_s > 8'd16)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            len_d   = byte_s[4:0];
            state_d = ST_DAT_H;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DAT_L: begin
        if (nib_stb) begin
          mem_d[cnt_q[3:0]] = byte_s;
          acc_d = acc_q ^ byte_s;
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == len_q) begin
            state_d = ST_CS_H;
          end else begin
            state_d = ST_DAT_H;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_CS_L: begin
        if (nib_stb) begin
          busy_d = 1'b0;
          if (byte_s == acc_q) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            last_addr_d = len_q[3:0] - 4'd1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, control and memory registers; reset also wipes the program.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hi_q        <= 4'd0;
      len_q       <= 5'd0;
      cnt_q       <= 5'd0;
      acc_q       <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      last_addr_q <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      last_addr_q <= last_addr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Contents are only exposed once a frame has verified and nothing is loading.
  assign cpu_instr = (done_q && !busy_q) ? mem_q[cpu_addr] : 8'h00;
  assign last_addr = last_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tiny_cpu_prog_loader.sv
// Scoreboard bench for tiny_cpu_prog_loader: expected status and memory reads
// are queued as frames are driven and popped as the DUT outputs are observed.
module tb_tiny_cpu_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] nib_in = 4'd0;
  logic       nib_stb = 1'b0;
  logic [3:0] cpu_addr = 4'd0;
  logic [7:0] cpu_instr;
  logic [3:0] last_addr;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] dat [16];

  tiny_cpu_prog_loader #(.DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .nib_in    (nib_in),
    .nib_stb   (nib_stb),
    .cpu_addr  (cpu_addr),
    .cpu_instr (cpu_instr),
    .last_addr (last_addr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  // Status word: {busy, done, err, last_addr}
  task automatic push_status(input string tag, input logic b, input logic d, input logic e, input logic [3:0] la);
    push_exp(tag, {25'd0, b, d, e, la});
  endtask

  task automatic obs_status();
    pop_chk({25'd0, busy, done, err, last_addr});
  endtask

  task automatic push_read(input string tag, input logic [3:0] a, input logic [7:0] v);
    push_exp(tag, {20'd0, a, v});
  endtask

  task automatic obs_read(input logic [3:0] a);
    cpu_addr = a;
    #1;
    pop_chk({20'd0, a, cpu_instr});
  endtask

  task automatic nib(input logic [3:0] n);
    @(negedge clk);
    nib_in  = n;
    nib_stb = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    nib(b[7:4]);
    nib(b[3:0]);
  endtask

  task automatic idle();
    @(negedge clk);
    nib_stb = 1'b0;
    start   = 1'b0;
  endtask

  task automatic pulse_start(input logic stb, input logic [3:0] n);
    @(negedge clk);
    start   = 1'b1;
    nib_stb = stb;
    nib_in  = n;
    @(negedge clk);
    start   = 1'b0;
    nib_stb = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] len_b, input int n, input logic [7:0] cs);
    send_byte(len_b);
    for (int i = 0; i < n; i++) begin
      send_byte(dat[i]);
    end
    send_byte(cs);
    idle();
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    push_status("reset_status", 1'b0, 1'b0, 1'b0, 4'd0);
    push_read("reset_instr", 4'd0, 8'h00);
    obs_status();
    obs_read(4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // good LEN=2 frame
    pulse_start(1'b0, 4'd0);
    push_status("start_busy", 1'b1, 1'b0, 1'b0, 4'd0);
    obs_status();
    dat[0] = 8'h35; dat[1] = 8'h12;
    send_frame(8'h02, 2, 8'h27);
    push_status("good2_status", 1'b0, 1'b1, 1'b0, 4'd1);
    obs_status();
    push_read("good2_rd0", 4'd0, 8'h35);
    push_read("good2_rd1", 4'd1, 8'h12);
    obs_read(4'd0);
    obs_read(4'd1);

    // bad checksum
    pulse_start(1'b0, 4'd0);
    send_frame(8'h02, 2, 8'h26);
    push_status("badcs_status", 1'b0, 1'b0, 1'b1, 4'd1);
    obs_status();
    for (int a = 0; a < 16; a++) begin
      push_read("badcs_gated", 4'(a), 8'h00);
      obs_read(4'(a));
    end

    // LEN out of range, trailing strobes ignored
    pulse_start(1'b0, 4'd0);
    send_byte(8'h00);
    idle();
    push_status("len0_err", 1'b0, 1'b0, 1'b1, 4'd1);
    obs_status();
    send_byte(8'h35);
    idle();
    push_status("len0_ignored", 1'b0, 1'b0, 1'b1, 4'd1);
    obs_status();
    pulse_start(1'b0, 4'd0);
    send_byte(8'h11);
    idle();
    push_status("len17_err", 1'b0, 1'b0, 1'b1, 4'd1);
    obs_status();
    send_byte(8'h01);
    send_byte(8'h07);
    idle();
    push_status("len17_ignored", 1'b0, 1'b0, 1'b1, 4'd1);
    obs_status();

    // full 16-byte program
    pulse_start(1'b0, 4'd0);
    for (int k = 0; k < 16; k++) dat[k] = 8'(k);
    send_frame(8'h10, 16, 8'h00);
    push_status("len16_status", 1'b0, 1'b1, 1'b0, 4'd15);
    obs_status();
    for (int a = 0; a < 16; a++) begin
      push_read("len16_rd", 4'(a), 8'(a));
      obs_read(4'(a));
    end

    // shorter program leaves upper addresses intact
    pulse_start(1'b0, 4'd0);
    dat[0] = 8'h35; dat[1] = 8'h12;
    send_frame(8'h02, 2, 8'h27);
    push_status("reload_status", 1'b0, 1'b1, 1'b0, 4'd1);
    obs_status();
    push_read("reload_rd1", 4'd1, 8'h12);
    push_read("reload_keep5", 4'd5, 8'h05);
    push_read("reload_keep15", 4'd15, 8'h0F);
    obs_read(4'd1);
    obs_read(4'd5);
    obs_read(4'd15);

    // asynchronous reset after 3 data bytes of a LEN=4 frame
    pulse_start(1'b0, 4'd0);
    send_byte(8'h04);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    push_status("rst_mid_status", 1'b0, 1'b0, 1'b0, 4'd0);
    push_read("rst_mid_instr", 4'd0, 8'h00);
    obs_status();
    obs_read(4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single-byte program exposes cleared memory above it
    pulse_start(1'b0, 4'd0);
    dat[0] = 8'hAA;
    send_frame(8'h01, 1, 8'hAA);
    push_status("len1_status", 1'b0, 1'b1, 1'b0, 4'd0);
    obs_status();
    for (int a = 0; a < 16; a++) begin
      push_read("post_rst_mem", 4'(a), (a == 0) ? 8'hAA : 8'h00);
      obs_read(4'(a));
    end

    // start with coincident strobe, then a second start mid-frame
    pulse_start(1'b1, 4'hF);
    push_status("restart_busy", 1'b1, 1'b0, 1'b0, 4'd0);
    push_read("restart_gated", 4'd0, 8'h00);
    obs_status();
    obs_read(4'd0);
    send_byte(8'h01);
    idle();
    pulse_start(1'b0, 4'd0);
    push_status("midframe_start_ignored", 1'b1, 1'b0, 1'b0, 4'd0);
    obs_status();
    send_byte(8'h5C);
    send_byte(8'h5C);
    idle();
    push_status("restart_done", 1'b0, 1'b1, 1'b0, 4'd0);
    push_read("restart_rd0", 4'd0, 8'h5C);
    obs_status();
    obs_read(4'd0);

    if (sb_q.size() != 0) begin
      check_val("scoreboard_leftover", 32'(sb_q.size()), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tiny_cpu_prog_loader.md
# tiny_cpu_prog_loader

Program-memory writer for the 4-bit accumulator CPU. It receives a framed program over a 4-bit nibble-serial host interface, checks the length and XOR checksum, and stores it in a 16 x 8 instruction memory. The CPU reads that memory by PC address. The block also reports the last valid program address, so the CPU PC can wrap at program end instead of at a fixed constant.

## Interface
- DEPTH, 16, instruction memory depth in bytes; fixed at 16 for a 4-bit PC.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse that begins a new load frame.
- nib_in  input  4  host data nibble.
- nib_stb  input  1  nib_in is valid this cycle; one nibble is consumed per strobe cycle.
- cpu_addr  input  4  CPU PC read address.
- cpu_instr  output  8  instruction at cpu_addr; combinational read, gated.
- last_addr  output  4  program length minus 1 from the last good load.
- busy  output  1  a frame is in progress.
- done  output  1  the last frame loaded and checked OK; sticky.
- err  output  1  the last frame failed; sticky.

## Operation
- Frame: LEN byte, then LEN data bytes, then CSUM byte.
  - Every byte is sent as two nibbles, high nibble first.
  - CSUM is the XOR of all data bytes, with initial value 0x00.
- FSM states: IDLE, LEN_H, LEN_L, DAT_H, DAT_L, CS_H, CS_L, DONE, ERR.
- Any state except LEN_H..CS_L, on start → LEN_H.
  - On entry, clear the byte counter, the XOR accumulator, done and err.
  - Set busy.
- start while busy is ignored.
- start and nib_stb in the same cycle from IDLE/DONE/ERR: start wins and the nibble is dropped.
- LEN_H/LEN_L: assemble the LEN byte.
  - On the LEN_L strobe, LEN == 0 or LEN > 16 → ERR.
  - Otherwise store LEN and go to DAT_H.
- DAT_H/DAT_L:
  - On the DAT_L strobe, write {hi, lo} to mem[byte_cnt], XOR it into the accumulator and increment byte_cnt.
  - When byte_cnt reaches LEN → CS_H; otherwise → DAT_H.
- CS_H/CS_L: on the CS_L strobe, compare {hi, lo} with the accumulator.
  - Match → DONE: set done, and set last_addr = LEN - 1.
  - Mismatch → ERR: set err; last_addr is unchanged.
- nib_stb in IDLE, DONE or ERR is ignored.
- States only advance on nib_stb; there is no timeout.
- cpu_instr = mem[cpu_addr] only when done = 1 and busy = 0; otherwise it is 0x00.
- Memory bytes written by a failed frame stay in the array but are hidden by the gate.
- Addresses at or above LEN keep their previous contents. The CPU must wrap using last_addr.

## Timing
- Reset values:
  - State IDLE; busy = 0, done = 0, err = 0.
  - last_addr = 0; cpu_instr = 0x00.
  - All 16 memory bytes = 0x00; all internal counters and the accumulator = 0.
- start sampled at edge N: busy = 1 after edge N, and the next nib_stb is taken as LEN high.
- Memory write occurs on the same edge that samples the DAT_L strobe. The byte is readable after done.
- Final CS_L strobe sampled at edge M:
  - busy = 0 and done or err = 1 after edge M.
  - cpu_instr is valid combinationally in the cycle after edge M.
- Minimum frame length is 2 + 2·LEN + 2 strobes. Back-to-back strobes on every cycle are supported.
- Asynchronous reset mid-frame:
  - Immediate return to IDLE with all outputs at reset values.
  - Memory clears to 0x00; the partial frame is discarded.

## Test plan
- start; nibbles 0,2, 3,5, 1,2, 2,7 (LEN = 2, data 0x35 and 0x12, CSUM 0x27) → done = 1, err = 0, last_addr = 1; cpu_addr 0 → 0x35, cpu_addr 1 → 0x12.
- Same frame but CSUM 0x26 → err = 1, done = 0, cpu_instr = 0x00 for every cpu_addr, last_addr unchanged.
- LEN = 0x00 and LEN = 0x11, each on a fresh start → err = 1 right after the LEN_L strobe; further strobes are ignored.
- LEN = 16 with data 0x00..0x0F and CSUM 0x00 → done = 1, last_addr = 15, mem[k] = k for all k.
- Assert rst_n low after 3 data bytes of a LEN = 4 frame → busy = 0, done = 0, err = 0, last_addr = 0, memory all 0x00.
- After a good load, pulse start together with nib_stb → nibble dropped, cpu_instr = 0x00 while busy, and a second start mid-frame is ignored.
